sram_song_loader: RTL and testbench
===================================

# sram_song_loader

Writes a song program into the external SRAM so the player core can later fetch it from address 0. Sits between a byte-stream source (UART receiver or host bridge) and the SRAM pins. It packs incoming bytes into 16-bit instruction words, high byte first, and runs an SRAM write cycle for each word. It stops after writing the END instruction (bits [15:12] = 4'b0000).

## Interface
- WE_CYCLES, 3: number of cycles SRAM_WE is held low per write (minimum 1).
- READ_CYCLES, 2: number of cycles SRAM_OE is held low per verify read. Used only with LOADER_VERIFY_EN.
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  reset; one clock, asynchronous, active-high.
- START  in  1  one-cycle pulse that begins a load at address 0.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA is valid.
- RX_READY  out  1  loader accepts the byte this cycle.
- BUSY  out  1  a load is in progress.
- DONE  out  1  load finished; sticky until the next START.
- ERR  out  1  load failed (address overflow or verify mismatch); sticky until the next START.
- WORD_COUNT  out  18  number of words written in the current or last load.
- SRAM_A  out  18  SRAM address.
- SRAM_DQ_O  out  16  write data.
- SRAM_DQ_OE  out  1  drive enable for the DQ tristate.
- SRAM_DQ_I  in  16  read data.
- SRAM_WE  out  1  write enable, active low.
- SRAM_CE  out  1  chip enable, active low.
- SRAM_OE  out  1  output enable, active low.
- SRAM_LB  out  1  lower byte enable, active low.
- SRAM_UB  out  1  upper byte enable, active low.

## Operation
- States: IDLE, HI, LO, SETUP, PULSE, HOLD, VRD (verify read, only with LOADER_VERIFY_EN), FIN.
- IDLE or FIN, START=1:
  - Clear DONE, ERR, WORD_COUNT and the address register.
  - Go to HI.
- START in any other state is ignored.
- HI: RX_READY=1. On the handshake (RX_VALID && RX_READY), latch the byte into word[15:8] and go to LO.
- LO: RX_READY=1. On the handshake, latch the byte into word[7:0] and go to SETUP.
- SETUP: 1 cycle.
  - SRAM_A = address, SRAM_DQ_O = word, SRAM_DQ_OE=1, SRAM_WE=1.
  - Go to PULSE.
- PULSE: WE_CYCLES cycles with SRAM_WE=0. Address and data held stable.
- HOLD: 1 cycle.
  - SRAM_WE=1; address and data still driven.
  - WORD_COUNT increments.
  - Then go to VRD if LOADER_VERIFY_EN is defined.
  - Otherwise, decide the next state as follows.
- Next-state decision after a write:
  - If word[15:12]==4'b0000, go to FIN with DONE=1.
  - Else if address==18'h3FFFF, go to FIN with ERR=1 and DONE=1.
  - Else increment the address and go to HI.
- FIN: BUSY=0, DONE=1. Waits for START.
- RX_READY is 0 in every state except HI and LO. Bytes offered outside HI and LO are not consumed.
- SRAM_CE, SRAM_LB, SRAM_UB are always 0.
- SRAM_OE=1 in all states except VRD.
- SRAM_DQ_OE=1 only in SETUP, PULSE and HOLD.
- BUSY=1 in HI, LO, SETUP, PULSE, HOLD and VRD.
- RST from any state:
  - Return to IDLE immediately and abort any write in progress.
  - SRAM_WE rises asynchronously with reset.

## Timing
- Reset values:
  - State IDLE; RX_READY=0, BUSY=0, DONE=0, ERR=0, WORD_COUNT=0.
  - SRAM_A=0, SRAM_DQ_O=0, SRAM_DQ_OE=0.
  - SRAM_WE=1, SRAM_OE=1, SRAM_CE=0, SRAM_LB=0, SRAM_UB=0.
- State and output changes are registered on the CLK rising edge. All outputs are registered.
- Bytes are accepted on the edge where RX_VALID && RX_READY. Back-to-back bytes are accepted on consecutive cycles.
- From the low-byte accept edge back to RX_READY=1 in HI: 1 + WE_CYCLES + 1 cycles, i.e. 5 cycles at the default. Verify adds READ_CYCLES cycles.
- The address never changes while SRAM_WE=0. Data is driven from SETUP through HOLD, giving one cycle of setup and one cycle of hold around the WE pulse.

## Configuration
- LOADER_VERIFY_EN defined:
  - After HOLD, enter VRD for READ_CYCLES cycles with SRAM_DQ_OE=0 and SRAM_OE=0.
  - Sample SRAM_DQ_I on the last VRD cycle.
  - If the sample differs from the written word, set ERR=1 and DONE=1 and go to FIN.
  - Otherwise apply the normal next-state decision.
- LOADER_VERIFY_EN undefined: the VRD state and SRAM_DQ_I are unused, and SRAM_OE stays 1 at all times.

## Test plan
- Reset, then START, then bytes 0x80,0x4F,0x10,0x60,0x00,0x00:
  - SRAM gets 0x804F at address 0, 0x1060 at address 1, 0x0000 at address 2.
  - WORD_COUNT=3, DONE=1, ERR=0.
- Single write at default WE_CYCLES: SRAM_WE is low for exactly 3 cycles. SRAM_A and SRAM_DQ_O are stable from one cycle before the fall to one cycle after the rise.
- RX_VALID held high continuously:
  - RX_READY is low for 5 cycles after every second byte.
  - No byte is dropped or duplicated; 8 bytes give 4 correct words.
- Preload the address to 18'h3FFFF via a bench force, then write a non-END word: ERR=1, DONE=1, no wrap to address 0.
- Assert RST during PULSE: SRAM_WE=1 in the same cycle, state is IDLE, BUSY=0. A following START rewrites from address 0.
- With LOADER_VERIFY_EN and the SRAM model corrupting bit 0: write 0x8001, read back 0x8000 -> ERR=1, DONE=1, WORD_COUNT=1.

Source files
------------

// File: rtl/sram_song_loader_if.sv
// Byte-stream handshake and SRAM pin bundle for sram_song_loader.
// master: the loader; slave: the byte source / SRAM side.
`timescale 1ns/1ps
interface sram_song_loader_if;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [17:0] WORD_COUNT;
    logic [17:0] SRAM_A;
    logic [15:0] SRAM_DQ_O;
    logic        SRAM_DQ_OE;
    logic [15:0] SRAM_DQ_I;
    logic        SRAM_WE;
    logic        SRAM_CE;
    logic        SRAM_OE;
    logic        SRAM_LB;
    logic        SRAM_UB;

    modport master (
        input  START, RX_DATA, RX_VALID, SRAM_DQ_I,
        output RX_READY, BUSY, DONE, ERR, WORD_COUNT,
               SRAM_A, SRAM_DQ_O, SRAM_DQ_OE, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB
    );

    modport slave (
        output START, RX_DATA, RX_VALID, SRAM_DQ_I,
        input  RX_READY, BUSY, DONE, ERR, WORD_COUNT,
               SRAM_A, SRAM_DQ_O, SRAM_DQ_OE, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB
    );
endinterface

// File: rtl/sram_song_loader.sv
// Packs a byte stream into 16-bit words (high byte first) and writes them to SRAM from address 0.
// Optional read-back verify of each word: define LOADER_VERIFY_EN.
`timescale 1ns/1ps
module sram_song_loader #(
    parameter int unsigned WE_CYCLES   = 3,
    parameter int unsigned READ_CYCLES = 2
) (
    input logic              CLK,
    input logic              RST,
    sram_song_loader_if.master bus
);

    localparam int unsigned CNT_MAX = (WE_CYCLES > READ_CYCLES) ? WE_CYCLES : READ_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE, HI, LO, SETUP, PULSE, HOLD, VRD, FIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        word_q, word_d;
    logic [17:0]        addr_q, addr_d;
    logic [17:0]        wcount_q, wcount_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rx_ready_q, rx_ready_d;
    logic               busy_q, busy_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               decide;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        addr_d   = addr_q;
        wcount_d = wcount_q;
        done_d   = done_q;
        err_d    = err_q;
        decide   = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                if (bus.START) begin
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    wcount_d = '0;
                    addr_d   = '0;
                    state_d  = HI;
                end
            end
            HI: begin
                if (bus.RX_VALID && rx_ready_q) begin
                    word_d[15:8] = bus.RX_DATA;
                    state_d      = LO;
                end
            end
            LO: begin
                if (bus.RX_VALID && rx_ready_q) begin
                    word_d[7:0] = bus.RX_DATA;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(WE_CYCLES - 1);
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            HOLD: begin
                wcount_d = wcount_q + 18'd1;
`ifdef LOADER_VERIFY_EN
                cnt_d    = CNT_W'(READ_CYCLES - 1);
                state_d  = VRD;
`else
                decide   = 1'b1;
`endif
            end
            VRD: begin
`ifdef LOADER_VERIFY_EN
                if (cnt_q == '0) begin
                    if (bus.SRAM_DQ_I != word_q) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        decide  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Post-write decision: END word stops cleanly, top address stops with error.
        if (decide) begin
            if (word_q[15:12] == 4'b0000) begin
                done_d  = 1'b1;
                state_d = FIN;
            end else if (addr_q == '1) begin
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = FIN;
            end else begin
                addr_d  = addr_q + 18'd1;
                state_d = HI;
            end
        end

        rx_ready_d = (state_d == HI) || (state_d == LO);
        busy_d     = (state_d != IDLE) && (state_d != FIN);
        dq_oe_d    = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
        we_n_d     = (state_d != PULSE);
        oe_n_d     = (state_d != VRD);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wcount_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            dq_oe_q    <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wcount_q   <= wcount_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            dq_oe_q    <= dq_oe_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
        end
    end

`ifndef LOADER_VERIFY_EN
    logic unused_cfg;
    assign unused_cfg = ^{bus.SRAM_DQ_I, 32'(READ_CYCLES)};
`endif

    assign bus.RX_READY   = rx_ready_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.ERR        = err_q;
    assign bus.WORD_COUNT = wcount_q;
    assign bus.SRAM_A     = addr_q;
    assign bus.SRAM_DQ_O  = word_q;
    assign bus.SRAM_DQ_OE = dq_oe_q;
    assign bus.SRAM_WE    = we_n_q;
    assign bus.SRAM_OE    = oe_n_q;
    assign bus.SRAM_CE    = 1'b0;
    assign bus.SRAM_LB    = 1'b0;
    assign bus.SRAM_UB    = 1'b0;

endmodule

// File: tb/tb_sram_song_loader.sv
// Self-checking bench for sram_song_loader: SRAM model, cycle-level timeline model, directed and random loads.
`timescale 1ns/1ps
module tb_sram_song_loader;

    localparam int unsigned WE_CYCLES   = 3;
    localparam int unsigned READ_CYCLES = 2;
`ifdef LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // Phase index counted from the low-byte accept edge: 0 = setup, 1..WE = pulse, WE+1 = hold.
    localparam int unsigned HOLD_N = WE_CYCLES + 1;
    localparam int unsigned LAST_N = WE_CYCLES + 2 + (VERIFY ? READ_CYCLES : 0);

    logic CLK = 1'b0;
    logic RST = 1'b1;

    sram_song_loader_if bus ();

    sram_song_loader #(
        .WE_CYCLES   (WE_CYCLES),
        .READ_CYCLES (READ_CYCLES)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #10 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External SRAM model; 'corrupt' flips bit 0 of every read.
    logic [15:0] mem [0:262143];
    bit          corrupt = 1'b0;
    int          preload_cnt = 0;

    always @(negedge CLK)
        if (!RST && bus.SRAM_WE == 1'b0 && bus.SRAM_CE == 1'b0)
            mem[bus.SRAM_A] <= bus.SRAM_DQ_O;

    assign bus.SRAM_DQ_I = mem[bus.SRAM_A] ^ {15'd0, corrupt};

    // Timeline model of the loader, checked on every falling edge.
    typedef enum {M_IDLE, M_HI, M_LO, M_WR, M_FIN} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int unsigned m_n = 0;
    logic [7:0]  m_hi = '0;
    logic [15:0] m_word = '0;
    logic [17:0] m_addr = '0;
    logic [17:0] m_wc = '0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;
    int          m_preload_seen = 0;

    always @(negedge CLK) begin
        bit e_rdy, e_busy, e_we, e_oe, e_dqoe;
        if (RST) begin
            m_mode = M_IDLE; m_addr = '0; m_wc = '0; m_done = 1'b0; m_err = 1'b0;
            m_preload_seen = preload_cnt;
        end else begin
            if (preload_cnt != m_preload_seen) begin
                m_preload_seen = preload_cnt;
                m_addr = 18'h3FFFF;
            end
            e_rdy = 1'b0; e_busy = 1'b0; e_we = 1'b1; e_oe = 1'b1; e_dqoe = 1'b0;
            case (m_mode)
                M_HI, M_LO: begin e_rdy = 1'b1; e_busy = 1'b1; end
                M_WR: begin
                    e_busy = 1'b1;
                    if (m_n <= HOLD_N) begin
                        e_dqoe = 1'b1;
                        e_we   = !(m_n >= 1 && m_n <= WE_CYCLES);
                        check("sram_a", 32'(bus.SRAM_A), 32'(m_addr));
                        check("sram_dq_o", 32'(bus.SRAM_DQ_O), 32'(m_word));
                    end else begin
                        e_oe = 1'b0;
                    end
                end
                default: ;
            endcase
            check("rx_ready", 32'(bus.RX_READY), 32'(e_rdy));
            check("busy", 32'(bus.BUSY), 32'(e_busy));
            check("sram_we", 32'(bus.SRAM_WE), 32'(e_we));
            check("sram_oe", 32'(bus.SRAM_OE), 32'(e_oe));
            check("sram_dq_oe", 32'(bus.SRAM_DQ_OE), 32'(e_dqoe));
            check("ce_lb_ub", 32'({bus.SRAM_CE, bus.SRAM_LB, bus.SRAM_UB}), 32'(0));
            check("done", 32'(bus.DONE), 32'(m_done));
            check("err", 32'(bus.ERR), 32'(m_err));
            check("word_count", 32'(bus.WORD_COUNT), 32'(m_wc));

            case (m_mode)
                M_IDLE, M_FIN: if (bus.START) begin
                    m_mode = M_HI; m_done = 1'b0; m_err = 1'b0; m_wc = '0; m_addr = '0;
                end
                M_HI: if (bus.RX_VALID) begin m_hi = bus.RX_DATA; m_mode = M_LO; end
                M_LO: if (bus.RX_VALID) begin m_word = {m_hi, bus.RX_DATA}; m_mode = M_WR; m_n = 0; end
                M_WR: begin
                    m_n++;
                    if (m_n == HOLD_N + 1) m_wc++;
                    if (m_n == LAST_N) begin
                        if (VERIFY && corrupt) begin
                            m_err = 1'b1; m_done = 1'b1; m_mode = M_FIN;
                        end else if (m_word[15:12] == 4'h0) begin
                            m_done = 1'b1; m_mode = M_FIN;
                        end else if (m_addr == 18'h3FFFF) begin
                            m_err = 1'b1; m_done = 1'b1; m_mode = M_FIN;
                        end else begin
                            m_addr++; m_mode = M_HI;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [7:0] tx_q [$];

    task automatic push_word(input logic [15:0] w);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    task automatic start_pulse();
        @(posedge CLK); #1 bus.START = 1'b1;
        @(posedge CLK); #1 bus.START = 1'b0;
    endtask

    // Feeds tx_q until the loader reports DONE; optional random valid gaps and stray START pulses.
    task automatic run_bytes(input bit cont, input bit rand_start);
        int cyc = 0;
        bit take;
        while (1) begin
            if (tx_q.size() > 0 && (cont || $urandom_range(0, 3) != 0)) begin
                bus.RX_VALID = 1'b1;
                bus.RX_DATA  = tx_q[0];
            end else begin
                bus.RX_VALID = 1'b0;
                bus.RX_DATA  = 8'($urandom);
            end
            bus.START = rand_start && ($urandom_range(0, 15) == 0);
            @(negedge CLK);
            take = bus.RX_VALID && bus.RX_READY;
            @(posedge CLK); #1;
            if (take) void'(tx_q.pop_front());
            cyc++;
            if (bus.DONE) break;
            if (cyc >= 2000) begin
                checks++; errors++;
                $display("FAIL load_timeout: DONE still %0b after %0d cycles, required 1", bus.DONE, cyc);
                break;
            end
        end
        bus.RX_VALID = 1'b0;
        bus.START    = 1'b0;
        tx_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] words [$];
        int unsigned n;

        bus.START = 1'b0; bus.RX_VALID = 1'b0; bus.RX_DATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rx_ready", 32'(bus.RX_READY), 32'(0));
        check("rst_busy", 32'(bus.BUSY), 32'(0));
        check("rst_done_err", 32'({bus.DONE, bus.ERR}), 32'(0));
        check("rst_word_count", 32'(bus.WORD_COUNT), 32'(0));
        check("rst_sram_a", 32'(bus.SRAM_A), 32'(0));
        check("rst_dq", 32'({bus.SRAM_DQ_O, bus.SRAM_DQ_OE}), 32'(0));
        check("rst_we_oe", 32'({bus.SRAM_WE, bus.SRAM_OE}), 32'(2'b11));
        RST = 1'b0;

        // Directed program from the datasheet example.
        start_pulse();
        push_word(16'h804F); push_word(16'h1060); push_word(16'h0000);
        run_bytes(1'b0, 1'b0);
        check("t1_mem0", 32'(mem[0]), 32'h804F);
        check("t1_mem1", 32'(mem[1]), 32'h1060);
        check("t1_mem2", 32'(mem[2]), 32'h0000);
        check("t1_word_count", 32'(bus.WORD_COUNT), 32'd3);
        check("t1_done_err", 32'({bus.DONE, bus.ERR}), 32'(2'b10));

        // RX_VALID held high: 8 bytes, 4 words.
        words.delete();
        for (int unsigned i = 0; i < 3; i++)
            words.push_back({4'($urandom_range(1, 15)), 12'($urandom)});
        words.push_back({4'h0, 12'($urandom)});
        start_pulse();
        foreach (words[i]) push_word(words[i]);
        run_bytes(1'b1, 1'b0);
        foreach (words[i]) check("t2_mem", 32'(mem[i]), 32'(words[i]));
        check("t2_word_count", 32'(bus.WORD_COUNT), 32'd4);

        // Random programs with gaps and ignored START pulses.
        for (int unsigned it = 0; it < 6; it++) begin
            n = $urandom_range(1, 6);
            words.delete();
            for (int unsigned i = 0; i + 1 < n; i++)
                words.push_back({4'($urandom_range(1, 15)), 12'($urandom)});
            words.push_back({4'h0, 12'($urandom)});
            start_pulse();
            foreach (words[i]) push_word(words[i]);
            run_bytes(1'b0, 1'b1);
            foreach (words[i]) check("t3_mem", 32'(mem[i]), 32'(words[i]));
            check("t3_word_count", 32'(bus.WORD_COUNT), 32'(n));
            check("t3_err", 32'(bus.ERR), 32'(0));
        end

        // Address overflow: preload the top address, write a non-END word.
        start_pulse();
        force dut.addr_q = 18'h3FFFF;
        preload_cnt++;
        @(posedge CLK); #1;
        release dut.addr_q;
        push_word(16'h1234); push_word(16'h5678);
        run_bytes(1'b0, 1'b0);
        check("t4_done_err", 32'({bus.DONE, bus.ERR}), 32'(2'b11));
        check("t4_word_count", 32'(bus.WORD_COUNT), 32'd1);
        check("t4_mem_top", 32'(mem[18'h3FFFF]), 32'h1234);
        check("t4_no_wrap", 32'(bus.SRAM_A), 32'h3FFFF);

        // Reset in the middle of a write pulse.
        start_pulse();
        bus.RX_VALID = 1'b1; bus.RX_DATA = 8'h8A;
        @(posedge CLK); #1 bus.RX_DATA = 8'hBC;
        @(posedge CLK); #1 bus.RX_VALID = 1'b0;
        for (int i = 0; i < 10 && bus.SRAM_WE !== 1'b0; i++) begin
            @(posedge CLK); #1;
        end
        check("t5_we_low", 32'(bus.SRAM_WE), 32'(0));
        RST = 1'b1;
        #1;
        check("t5_we_async", 32'(bus.SRAM_WE), 32'(1));
        check("t5_busy", 32'(bus.BUSY), 32'(0));
        check("t5_idle_outs", 32'({bus.RX_READY, bus.SRAM_DQ_OE, bus.DONE}), 32'(0));
        @(posedge CLK); #1 RST = 1'b0;
        start_pulse();
        push_word(16'h0ABC);
        run_bytes(1'b0, 1'b0);
        check("t5_mem0", 32'(mem[0]), 32'h0ABC);
        check("t5_word_count", 32'(bus.WORD_COUNT), 32'd1);
        check("t5_done_err", 32'({bus.DONE, bus.ERR}), 32'(2'b10));

`ifdef LOADER_VERIFY_EN
        // Read-back mismatch on bit 0.
        corrupt = 1'b1;
        start_pulse();
        push_word(16'h8001); push_word(16'h1111);
        run_bytes(1'b0, 1'b0);
        check("t6_done_err", 32'({bus.DONE, bus.ERR}), 32'(2'b11));
        check("t6_word_count", 32'(bus.WORD_COUNT), 32'd1);
        check("t6_mem0", 32'(mem[0]), 32'h8001);
        @(posedge CLK); #1 corrupt = 1'b0;
`endif

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
